sort_unloader: RTL and testbench

SORT_UNLOADER -- requirements
Module: sort_unloader

---
 rtl/sort_unloader.sv | 143 ++++++++++++++
 tb/tb_sort_unloader.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sort_unloader.sv
// Streams memory words 0..num-1 out through a 2-entry FIFO with valid/ready.
// Optional feature macro: SORT_UNLOADER_ORDER_CHECK_EN (unsigned ascending check).
module sort_unloader #(
  parameter int MM = 256,
  parameter int MN = 32,
  parameter int MW = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [MW:0]   num,
  output logic          busy,
  output logic          done,
  output logic          MemRd,
  output logic [MW-1:0] MemRdAddr,
  input  logic [MN-1:0] MemRdData,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [MN-1:0] out_data,
  output logic          out_last,
  output logic          order_err
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } state_t;

  localparam logic [MW:0] MM_W = (MW+1)'(MM);

  state_t state;
  logic [MW:0] rd;
  logic [MW:0] num_q;
  logic [MW:0] num_eff;
  logic rd_pend;
  logic rd_pend_last;
  logic rd_last;
  logic [2:0] credit;

  logic [1:0][MN-1:0] fifo_d;
  logic [1:0] fifo_l;
  logic wptr;
  logic rptr;
  logic [1:0] occ;
  logic push;
  logic pop;
  logic accept;

  assign num_eff = (num > MM_W) ? MM_W : num;
  assign accept = (state == IDLE) && start;
  assign push = rd_pend;
  assign pop = out_valid && out_ready;
  assign rd_last = (rd == num_q - 1'b1);
  assign credit = {1'b0, occ} + {2'b0, rd_pend};

  // A slot being popped this cycle counts as free, keeping full throughput.
  assign MemRd = (state == READ)
    && ((credit - {2'b0, pop}) < 3'd2);
  assign MemRdAddr = rd[MW-1:0];

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  assign out_valid = (occ != 2'd0);
  assign out_data = fifo_d[rptr];
  assign out_last = out_valid && fifo_l[rptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      rd <= '0;
      num_q <= '0;
      rd_pend <= 1'b0;
      rd_pend_last <= 1'b0;
    end else begin
      rd_pend <= MemRd;
      rd_pend_last <= MemRd && rd_last;
      unique case (state)
        IDLE: begin
          if (start) begin
            num_q <= num_eff;
            rd <= '0;
            state <= (num_eff == '0) ? DONE : READ;
          end
        end
        READ: begin
          if (MemRd) begin
            rd <= rd + 1'b1;
            if (rd_last) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && out_last) state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fifo_d <= '0;
      fifo_l <= '0;
      wptr <= 1'b0;
      rptr <= 1'b0;
      occ <= '0;
    end else begin
      if (push) begin
        fifo_d[wptr] <= MemRdData;
        fifo_l[wptr] <= rd_pend_last;
        wptr <= ~wptr;
      end
      if (pop) rptr <= ~rptr;
      occ <= occ + {1'b0, push} - {1'b0, pop};
    end
  end

`ifdef SORT_UNLOADER_ORDER_CHECK_EN
  logic [MN-1:0] prev;
  logic have_prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev <= '0;
      have_prev <= 1'b0;
      order_err <= 1'b0;
    end else if (accept) begin
      have_prev <= 1'b0;
      order_err <= 1'b0;
    end else if (pop) begin
      prev <= out_data;
      have_prev <= 1'b1;
      if (have_prev && (out_data < prev)) order_err <= 1'b1;
    end
  end
`else
  assign order_err = 1'b0;
`endif

endmodule

// File: tb/tb_sort_unloader.sv
// Scoreboard bench for sort_unloader: directed unloads against a
// registered memory model, with a decoupled output monitor.
module tb_sort_unloader;

`ifdef SORT_UNLOADER_ORDER_CHECK_EN
  localparam bit OC = 1'b1;
`else
  localparam bit OC = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic [8:0] num = '0;
  logic busy, done, MemRd, out_valid, out_last, order_err;
  logic [7:0] MemRdAddr;
  logic [31:0] MemRdData = '0;
  logic out_ready = 1'b1;
  logic [31:0] out_data;

  logic [31:0] mem [256];
  logic [32:0] sb [$];
  int checks = 0;
  int errors = 0;
  int xfer = 0;

  sort_unloader #(.MM(256), .MN(32), .MW(8)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .num(num),
    .busy(busy),
    .done(done),
    .MemRd(MemRd),
    .MemRdAddr(MemRdAddr),
    .MemRdData(MemRdData),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_last(out_last),
    .order_err(order_err)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) if (MemRd) MemRdData <= mem[MemRdAddr];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Output monitor: pops the scoreboard on every transfer.
  initial begin
    logic stall;
    logic [31:0] hd;
    logic hl;
    logic [32:0] e;
    stall = 1'b0;
    hd = '0;
    hl = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          chk("stall_valid", 64'(out_valid), 64'd1);
          chk("stall_data", 64'({out_last, out_data}), 64'({hl, hd}));
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            chk("unexpected_xfer", 64'(out_data), 64'hFFFF_FFFF_FFFF);
          end else begin
            e = sb.pop_front();
            chk("xfer", 64'({out_last, out_data}), 64'(e));
          end
          xfer++;
        end
        stall = out_valid && !out_ready;
        hd = out_data;
        hl = out_last;
      end
    end
  end

  task automatic wait_done(input int limit);
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (done) return;
    end
    chk("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic kick(input int n);
    num = 9'(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_memrd"}, 64'(MemRd), 64'd0);
    chk({tag, "_addr"}, 64'(MemRdAddr), 64'd0);
    chk({tag, "_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_data"}, 64'(out_data), 64'd0);
    chk({tag, "_last"}, 64'(out_last), 64'd0);
    chk({tag, "_oerr"}, 64'(order_err), 64'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    reset_n = 1'b1;
    @(negedge clk);

    // Basic latency: {1,2,3,4}
    for (int i = 0; i < 4; i++) mem[i] = 32'(i + 1);
    sb.push_back({1'b0, 32'd1});
    sb.push_back({1'b0, 32'd2});
    sb.push_back({1'b0, 32'd3});
    sb.push_back({1'b1, 32'd4});
    num = 9'd4;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("lat_memrd_c%0d", k), 64'(MemRd),
          64'(k >= 1 && k <= 4));
      chk($sformatf("lat_valid_c%0d", k), 64'(out_valid),
          64'(k >= 3 && k <= 6));
      chk($sformatf("lat_done_c%0d", k), 64'(done), 64'(k == 7));
      @(negedge clk);
    end
    chk("lat_sb_empty", 64'(sb.size()), 64'd0);

    // Zero-length unload
    kick(0);
    for (int k = 1; k <= 3; k++) begin
      chk($sformatf("zero_done_c%0d", k), 64'(done), 64'(k == 1));
      chk($sformatf("zero_memrd_c%0d", k), 64'(MemRd), 64'd0);
      chk($sformatf("zero_valid_c%0d", k), 64'(out_valid), 64'd0);
      @(negedge clk);
    end

    // Back-pressure with out_ready 1,0,0,1
    for (int i = 0; i < 8; i++) begin
      mem[i] = 32'(i * 7 + 2);
      sb.push_back({(i == 7), 32'(i * 7 + 2)});
    end
    num = 9'd8;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    begin
      logic [3:0] pat;
      bit seen;
      pat = 4'b1001;
      seen = 1'b0;
      for (int c = 0; c < 200 && !seen; c++) begin
        @(posedge clk);
        #1;
        out_ready = pat[c % 4];
        if (done) seen = 1'b1;
      end
      chk("bp_done_seen", 64'(seen), 64'd1);
    end
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("bp_sb_empty", 64'(sb.size()), 64'd0);

    // Order check {5,3}
    mem[0] = 32'd5;
    mem[1] = 32'd3;
    sb.push_back({1'b0, 32'd5});
    sb.push_back({1'b1, 32'd3});
    kick(2);
    chk("ord_before", 64'(order_err), 64'd0);
    wait_done(20);
    chk("ord_at_done", 64'(order_err), 64'(OC));
    repeat (3) @(negedge clk);
    chk("ord_sticky", 64'(order_err), 64'(OC));
    kick(0);
    chk("ord_cleared", 64'(order_err), 64'd0);
    repeat (2) @(negedge clk);

    // Asynchronous reset after 3rd transfer of num=10
    for (int i = 0; i < 10; i++) begin
      mem[i] = 32'(100 + i);
      sb.push_back({(i == 9), 32'(100 + i)});
    end
    xfer = 0;
    kick(10);
    begin
      bit hit;
      hit = 1'b0;
      for (int c = 0; c < 50 && !hit; c++) begin
        @(posedge clk);
        if (xfer == 3) hit = 1'b1;
      end
      chk("rst_third_xfer", 64'(hit), 64'd1);
    end
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    sb.delete();
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("post_rst_no_done", 64'(done), 64'd0);
    end
    mem[0] = 32'h0000_00AA;
    mem[1] = 32'h0000_00BB;
    sb.push_back({1'b0, 32'h0000_00AA});
    sb.push_back({1'b1, 32'h0000_00BB});
    num = 9'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_addr0", 64'(MemRdAddr), 64'd0);
    chk("restart_memrd", 64'(MemRd), 64'd1);
    wait_done(20);
    @(negedge clk);
    chk("restart_sb_empty", 64'(sb.size()), 64'd0);

    // Oversized count clamps to 256
    for (int i = 0; i < 256; i++) begin
      mem[i] = 32'(i);
      sb.push_back({(i == 255), 32'(i)});
    end
    xfer = 0;
    kick(300);
    wait_done(400);
    @(negedge clk);
    chk("clamp_count", 64'(xfer), 64'd256);
    chk("clamp_sb_empty", 64'(sb.size()), 64'd0);
    chk("clamp_idle", 64'(busy), 64'd0);
    chk("clamp_oerr", 64'(order_err), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
